// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: buffer entry layout, NOP encoding and default reset address.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch buffer of fetch entries with push/pop/flush and occupancy count.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  fetch_entry_t    push_data,
  input  logic            pop,
  input  logic            flush,
  output fetch_entry_t    head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  // Pointer and occupancy next-state; flush overrides everything.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A push into a full buffer is legal only when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) count_d = count_q + CntW'(1);
      if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches, buffers in-order responses,
// and discards responses belonging to requests issued before a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if (!(DEPTH == 2 || DEPTH == 4)) begin : g_bad_depth
    $error("fetch_unit: DEPTH must be 2 or 4");
  end

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;    // pc of the next response that will be kept
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_q, drop_d;

  fetch_entry_t    fifo_head;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   in_flight;
  logic            req_fire, resp_ok, drop_hit, push, pop;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Handshake decode and request credit: never issue more than the buffer can absorb.
  always_comb begin
    in_flight      = {1'b0, outstanding_q} + {1'b0, fifo_count};
    imem_req_valid = !reset && !redirect_valid && (in_flight < (CntW + 1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding are protocol errors and are ignored.
    resp_ok        = imem_resp_valid && (outstanding_q != '0);
    drop_hit       = resp_ok && (drop_q != '0);
    push           = resp_ok && !drop_hit && !redirect_valid;
    out_valid      = !fifo_empty && !redirect_valid;
    pop            = out_valid && out_ready;
    out_pc         = fifo_empty ? '0 : fifo_head.pc;
    out_inst       = fifo_empty ? '0 : fifo_head.inst;
  end

  // Next-state for fetch address, response address, outstanding and drop counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (req_fire && !resp_ok) outstanding_d = outstanding_q + CntW'(1);
    if (!req_fire && resp_ok) outstanding_d = outstanding_q - CntW'(1);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      // Everything still in flight belongs to the abandoned path.
      drop_d     = outstanding_q - CntW'(resp_ok);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)     resp_pc_d  = resp_pc_q + 32'd4;
      if (drop_hit) drop_d     = drop_q - CntW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Simulation-only protocol checks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_resp_valid && outstanding_q == '0))
        else $error("fetch_unit: imem_resp_valid with no outstanding request");
      assert (!(push && fifo_full && !pop))
        else $error("fetch_unit: prefetch buffer overflow");
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{pc: resp_pc_q, inst: imem_resp_inst}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model and an expected-output queue.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           first_req_cyc = -1;
  int           first_out_cyc = -1;
  int           base;
  logic         mem_hold = 1'b0;
  fetch_entry_t sb[$];
  logic [31:0]  mem_q[$];
  logic [31:0]  req_log[$];
  logic [31:0]  out_log[$];

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, then sample and score.
  task automatic cycle(input logic ordy, input logic qrdy, input logic redir,
                       input logic [31:0] rpc);
    fetch_entry_t e;
    @(negedge clk);
    reset          = 1'b0;
    out_ready      = ordy;
    imem_req_ready = qrdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (mem_q.size() != 0 && !mem_hold) begin
      imem_resp_valid = 1'b1;
      imem_resp_inst  = mem_word(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_inst  = '0;
    end
    #1;
    cyc++;
    if (redir) begin
      check("redir_out_valid", 32'(out_valid), 32'd0);
      check("redir_req_valid", 32'(imem_req_valid), 32'd0);
      sb.delete();
      req_log.delete();
      out_log.delete();
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back(imem_req_addr);
      sb.push_back('{pc: imem_req_addr, inst: mem_word(imem_req_addr)});
      req_log.push_back(imem_req_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      out_log.push_back(out_pc);
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_inst", out_inst, e.inst);
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset           = 1'b1;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    out_ready       = 1'b0;
    imem_req_ready  = 1'b1;
    mem_q.delete();
    sb.delete();
    req_log.delete();
    out_log.delete();
    repeat (n - 1) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    first_req_cyc = -1;
    first_out_cyc = -1;
  endtask

  initial begin
    do_reset(3);

    // Sequential fetch, zero-wait memory.
    cycle(1, 1, 0, 0);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    repeat (10) cycle(1, 1, 0, 0);
    check("seq_count", 32'(out_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) check("seq_pc", out_log[i], 32'(4 * i));
    check("first_latency", 32'(first_out_cyc - first_req_cyc), 32'd2);

    // Decode stall: request credit limits issue, nothing lost afterwards.
    base = req_log.size();
    repeat (10) cycle(0, 1, 0, 0);
    check("stall_reqs", 32'((req_log.size() - base) <= DEPTH), 32'd1);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_buffered", 32'(sb.size()), 32'(DEPTH));
    repeat (8) cycle(1, 1, 0, 0);

    // Memory back-pressure holds the address.
    cycle(1, 1, 1, 32'h8);
    repeat (3) begin
      cycle(1, 0, 0, 0);
      check("hold_valid", 32'(imem_req_valid), 32'd1);
      check("hold_addr", imem_req_addr, 32'h8);
    end
    cycle(1, 1, 0, 0);
    check("hold_accept_addr", imem_req_addr, 32'h8);
    cycle(1, 1, 0, 0);
    check("hold_next_addr", imem_req_addr, 32'hC);
    repeat (4) cycle(1, 1, 0, 0);

    // Redirect with two requests outstanding: both responses dropped.
    mem_hold = 1'b0;
    cycle(1, 1, 1, 32'h200);
    mem_hold = 1'b1;
    repeat (3) cycle(1, 1, 0, 0);
    check("drop_outstanding", 32'(mem_q.size()), 32'd2);
    check("drop_req_blocked", 32'(imem_req_valid), 32'd0);
    cycle(1, 1, 1, 32'h103);
    mem_hold = 1'b0;
    cycle(1, 1, 0, 0);
    check("drop_new_addr", imem_req_addr, 32'h100);
    repeat (8) cycle(1, 1, 0, 0);
    check("drop_req_n", 32'(req_log.size() > 0), 32'd1);
    check("drop_first_req", req_log[0], 32'h100);
    check("drop_out_n", 32'(out_log.size() > 0), 32'd1);
    check("drop_first_out", out_log[0], 32'h100);

    // Back-to-back redirects with responses landing in the redirect cycles.
    cycle(1, 1, 1, 32'h500);
    mem_hold = 1'b1;
    repeat (3) cycle(1, 1, 0, 0);
    mem_hold = 1'b0;
    cycle(1, 1, 1, 32'h600);
    cycle(1, 1, 1, 32'h704);
    repeat (8) cycle(1, 1, 0, 0);
    check("b2b_req_n", 32'(req_log.size() > 0), 32'd1);
    check("b2b_first_req", req_log[0], 32'h704);
    check("b2b_out_n", 32'(out_log.size() > 0), 32'd1);
    check("b2b_first_out", out_log[0], 32'h704);

    // Address wrap at the top of the space.
    cycle(1, 1, 1, 32'hFFFF_FFFC);
    repeat (6) cycle(1, 1, 0, 0);
    check("wrap_req_n", 32'(req_log.size() >= 2), 32'd1);
    check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
    check("wrap_req1", req_log[1], 32'h0000_0000);

    // Reset in the middle of activity.
    repeat (4) cycle(0, 1, 0, 0);
    check("mid_buffered", 32'(sb.size()), 32'(DEPTH));
    do_reset(2);
    cycle(1, 1, 0, 0);
    check("post_rst_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_addr", imem_req_addr, RESET_PC);
    repeat (6) cycle(1, 1, 0, 0);
    check("post_rst_out_n", 32'(out_log.size() > 0), 32'd1);
    check("post_rst_out", out_log[0], RESET_PC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
